// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with a one-deep result register.
// Single-cycle ops present their result on the cycle after accept.
// Optional iterative multiplier is compiled only when ALU_MUL_EN is defined.
module alu_seq #(
  parameter int N    = 8,
  parameter int NSel = 6
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [N-1:0]    i_alu_A,
  input  logic [N-1:0]    i_alu_B,
  input  logic [NSel-1:0] i_alu_Op,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [N-1:0]    o_alu_Result,
  output logic            o_zero,
  output logic            o_negative,
  output logic            o_carry,
  output logic            o_overflow,
  output logic            o_invalid
);

  localparam logic [NSel-1:0] OP_ADD = NSel'(6'b100000);
  localparam logic [NSel-1:0] OP_SUB = NSel'(6'b100010);
  localparam logic [NSel-1:0] OP_AND = NSel'(6'b100100);
  localparam logic [NSel-1:0] OP_OR  = NSel'(6'b100101);
  localparam logic [NSel-1:0] OP_XOR = NSel'(6'b100110);
  localparam logic [NSel-1:0] OP_NOR = NSel'(6'b100111);
  localparam logic [NSel-1:0] OP_SRL = NSel'(6'b000010);
  localparam logic [NSel-1:0] OP_SRA = NSel'(6'b000011);
  localparam logic [NSel-1:0] OP_SLL = NSel'(6'b000000);
`ifdef ALU_MUL_EN
  localparam logic [NSel-1:0] OP_MUL = NSel'(6'b011000);
  localparam int              CNT_W  = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
`endif
  // Shift amounts at or above this value shift everything out.
  localparam logic [N-1:0] SHIFT_LIMIT = N'(N);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic           ready_s;
  logic           accept_s;
  logic           is_mul_s;
  logic           mul_last_s;

  logic [N:0]     add_s;
  logic [N:0]     sub_s;
  logic [N-1:0]   alu_res_s;
  logic           alu_zero_s;
  logic           alu_neg_s;
  logic           alu_carry_s;
  logic           alu_ovf_s;
  logic           alu_inv_s;
  logic           op_known_s;

  logic [N-1:0]   result_r;
  logic           zero_r;
  logic           neg_r;
  logic           carry_r;
  logic           ovf_r;
  logic           inv_r;

`ifdef ALU_MUL_EN
  logic [2*N-1:0] mcand_r;
  logic [N-1:0]   mplier_r;
  logic [2*N-1:0] prod_r;
  logic [2*N-1:0] prod_nxt_s;
  logic [CNT_W-1:0] cnt_r;

  assign is_mul_s   = (i_alu_Op == OP_MUL);
  assign mul_last_s = (state_r == ST_BUSY) && (cnt_r == CNT_LAST);

  // Next partial sum: add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    if (mplier_r[0]) begin
      prod_nxt_s = prod_r + mcand_r;
    end else begin
      prod_nxt_s = prod_r;
    end
  end

  // Shift-add multiplier datapath: load on accept, one partial product per BUSY cycle.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      mcand_r  <= {(2*N){1'b0}};
      mplier_r <= {N{1'b0}};
      prod_r   <= {(2*N){1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else if (accept_s && is_mul_s) begin
      mcand_r  <= {{N{1'b0}}, i_alu_A};
      mplier_r <= i_alu_B;
      prod_r   <= {(2*N){1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else if (state_r == ST_BUSY) begin
      mcand_r  <= {mcand_r[2*N-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[N-1:1]};
      prod_r   <= prod_nxt_s;
      cnt_r    <= cnt_r + CNT_W'(1);
    end
  end
`else
  assign is_mul_s   = 1'b0;
  assign mul_last_s = 1'b0;
`endif

  // Single-cycle ALU: result and flags straight from the presented operands.
  always_comb begin
    add_s       = {1'b0, i_alu_A} + {1'b0, i_alu_B};
    sub_s       = {1'b0, i_alu_A} - {1'b0, i_alu_B};
    alu_res_s   = {N{1'b0}};
    alu_carry_s = 1'b0;
    alu_ovf_s   = 1'b0;
    alu_inv_s   = 1'b0;
    op_known_s  = 1'b1;
    case (i_alu_Op)
      OP_ADD: begin
        alu_res_s   = add_s[N-1:0];
        alu_carry_s = add_s[N];
        alu_ovf_s   = (i_alu_A[N-1] == i_alu_B[N-1]) && (add_s[N-1] != i_alu_A[N-1]);
      end
      OP_SUB: begin
        alu_res_s   = sub_s[N-1:0];
        alu_carry_s = ~sub_s[N];
        alu_ovf_s   = (i_alu_A[N-1] != i_alu_B[N-1]) && (sub_s[N-1] != i_alu_A[N-1]);
      end
      OP_AND: alu_res_s = i_alu_A & i_alu_B;
      OP_OR:  alu_res_s = i_alu_A | i_alu_B;
      OP_XOR: alu_res_s = i_alu_A ^ i_alu_B;
      OP_NOR: alu_res_s = ~(i_alu_A | i_alu_B);
      OP_SRL: begin
        if (i_alu_B >= SHIFT_LIMIT) begin
          alu_res_s = {N{1'b0}};
        end else begin
          alu_res_s = i_alu_A >> i_alu_B;
        end
      end
      OP_SRA: begin
        if (i_alu_B >= SHIFT_LIMIT) begin
          alu_res_s = {N{i_alu_A[N-1]}};
        end else begin
          alu_res_s = $signed(i_alu_A) >>> i_alu_B;
        end
      end
      OP_SLL: begin
        if (i_alu_B >= SHIFT_LIMIT) begin
          alu_res_s = {N{1'b0}};
        end else begin
          alu_res_s = i_alu_A << i_alu_B;
        end
      end
`ifdef ALU_MUL_EN
      OP_MUL: alu_res_s = {N{1'b0}};
`endif
      default: begin
        alu_inv_s  = 1'b1;
        op_known_s = 1'b0;
      end
    endcase
    alu_zero_s = op_known_s && (alu_res_s == {N{1'b0}});
    alu_neg_s  = op_known_s && alu_res_s[N-1];
  end

  // Handshake and next-state decode.
  always_comb begin
    ready_s     = 1'b0;
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: ready_s = 1'b1;
      ST_DONE: ready_s = i_ready;
      ST_BUSY: ready_s = 1'b0;
      default: ready_s = 1'b0;
    endcase
    accept_s = i_valid && ready_s;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          if (is_mul_s) begin
            state_nxt_s = ST_BUSY;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end else if ((state_r == ST_DONE) && i_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_BUSY: begin
        if (mul_last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Result/flag register: loads on single-cycle accept or multiply completion, otherwise holds.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      result_r <= {N{1'b0}};
      zero_r   <= 1'b0;
      neg_r    <= 1'b0;
      carry_r  <= 1'b0;
      ovf_r    <= 1'b0;
      inv_r    <= 1'b0;
    end else if (accept_s && !is_mul_s) begin
      result_r <= alu_res_s;
      zero_r   <= alu_zero_s;
      neg_r    <= alu_neg_s;
      carry_r  <= alu_carry_s;
      ovf_r    <= alu_ovf_s;
      inv_r    <= alu_inv_s;
`ifdef ALU_MUL_EN
    end else if (mul_last_s) begin
      result_r <= prod_nxt_s[N-1:0];
      zero_r   <= (prod_nxt_s[N-1:0] == {N{1'b0}});
      neg_r    <= prod_nxt_s[N-1];
      carry_r  <= 1'b0;
      ovf_r    <= |prod_nxt_s[2*N-1:N];
      inv_r    <= 1'b0;
`endif
    end
  end

  assign o_ready      = ready_s;
  assign o_valid      = (state_r == ST_DONE);
  assign o_alu_Result = result_r;
  assign o_zero       = zero_r;
  assign o_negative   = neg_r;
  assign o_carry      = carry_r;
  assign o_overflow   = ovf_r;
  assign o_invalid    = inv_r;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (N=8): directed vector table, multi-cycle
// handshake/reset sequences, and randomized traffic against a reference model.
module tb_alu_seq;
  localparam int N    = 8;
  localparam int NSEL = 6;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SLL = 6'b000000;
  localparam logic [5:0] OP_MUL = 6'b011000;

  // {result, zero, negative, carry, overflow, invalid}
  typedef struct packed {
    logic [7:0] res;
    logic       z;
    logic       n;
    logic       c;
    logic       v;
    logic       inv;
  } exp_t;

  typedef struct {
    logic [5:0] op;
    logic [7:0] a;
    logic [7:0] b;
    exp_t       e;
  } vec_t;

  logic       i_clock = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [7:0] i_alu_A = 8'h00;
  logic [7:0] i_alu_B = 8'h00;
  logic [5:0] i_alu_Op = 6'b000000;
  logic       o_valid;
  logic       i_ready = 1'b0;
  logic [7:0] o_alu_Result;
  logic       o_zero, o_negative, o_carry, o_overflow, o_invalid;

  int n_cmp  = 0;
  int n_fail = 0;

  vec_t       tbl [16];
  logic [5:0] ops [10];
  exp_t       q [$];

  alu_seq #(.N(N), .NSel(NSEL)) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_alu_A      (i_alu_A),
    .i_alu_B      (i_alu_B),
    .i_alu_Op     (i_alu_Op),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_alu_Result (o_alu_Result),
    .o_zero       (o_zero),
    .o_negative   (o_negative),
    .o_carry      (o_carry),
    .o_overflow   (o_overflow),
    .o_invalid    (o_invalid)
  );

  always #5 i_clock = ~i_clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t dut_out();
    return {o_alu_Result, o_zero, o_negative, o_carry, o_overflow, o_invalid};
  endfunction

  function automatic vec_t mkv(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] r, input logic [4:0] f);
    vec_t v;
    v.op = op;
    v.a  = a;
    v.b  = b;
    v.e  = {r, f};
    return v;
  endfunction

  // Reference model: plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int ua, ub, sa, sb, r, s;
    bit known;
    e     = '0;
    known = 1'b1;
    ua    = int'(a);
    ub    = int'(b);
    sa    = (ua >= 128) ? ua - 256 : ua;
    sb    = (ub >= 128) ? ub - 256 : ub;
    r     = 0;
    case (op)
      OP_ADD: begin r = ua + ub; e.c = (r > 255); s = sa + sb; e.v = (s > 127) || (s < -128); end
      OP_SUB: begin r = ua - ub; e.c = (ua >= ub); s = sa - sb; e.v = (s > 127) || (s < -128); end
      OP_AND: r = ua & ub;
      OP_OR:  r = ua | ub;
      OP_XOR: r = ua ^ ub;
      OP_NOR: r = ~(ua | ub);
      OP_SRL: r = (ub >= 8) ? 0 : ua / (1 << ub);
      OP_SRA: r = (ub >= 8) ? ((sa < 0) ? -1 : 0) : (sa >>> ub);
      OP_SLL: r = (ub >= 8) ? 0 : ua * (1 << ub);
`ifdef ALU_MUL_EN
      OP_MUL: begin r = ua * ub; e.v = (r > 255); end
`endif
      default: known = 1'b0;
    endcase
    if (known) begin
      e.res = 8'(r);
      e.z   = (e.res == 8'h00);
      e.n   = e.res[7];
    end else begin
      e.inv = 1'b1;
    end
    return e;
  endfunction

  task automatic go_idle();
    @(posedge i_clock); #1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (2) @(posedge i_clock);
    #1;
  endtask

  // One randomized cycle: drive after the edge, score at the falling edge.
  task automatic rnd_cycle(input bit allow_new);
    int idx;
    @(posedge i_clock); #1;
    if (allow_new) begin
      i_valid = ($urandom_range(0, 3) != 0);
      idx     = $urandom_range(0, 10);
      if (idx == 10) begin
        i_alu_Op = 6'($urandom);
      end else begin
        i_alu_Op = ops[idx];
      end
      i_alu_A = 8'($urandom);
      i_alu_B = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom);
      i_ready = ($urandom_range(0, 3) != 0);
    end else begin
      i_valid = 1'b0;
      i_ready = 1'b1;
    end
    @(negedge i_clock);
    if (o_valid) begin
      check("rnd_ready_vs_consumer", 32'(o_ready), 32'(i_ready));
      check("rnd_pending", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        check("rnd_out", 32'(dut_out()), 32'(q[0]));
        if (i_ready) begin
          void'(q.pop_front());
        end
      end
    end else begin
      check("rnd_ready_idle_busy", 32'(o_ready), 32'(q.size() == 0));
    end
    if (i_valid && o_ready) begin
      q.push_back(model(i_alu_Op, i_alu_A, i_alu_B));
    end
  endtask

  // Assert reset asynchronously while an operation is in flight and not yet consumed.
  task automatic rst_midflight(input string tag, input logic [5:0] op);
    int seen;
    go_idle();
    i_valid  = 1'b1;
    i_alu_Op = op;
    i_alu_A  = 8'h03;
    i_alu_B  = 8'h05;
    i_ready  = 1'b0;
    @(posedge i_clock); #1;
    i_valid = 1'b0;
    @(posedge i_clock); #2;
    i_reset = 1'b1;
    #1;
    check({tag, "_valid_async"}, 32'(o_valid), 32'd0);
    check({tag, "_out_async"}, 32'(dut_out()), 32'd0);
    #1;
    i_reset = 1'b0;
    @(negedge i_clock);
    check({tag, "_ready_after"}, 32'(o_ready), 32'd1);
    i_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge i_clock);
      if (o_valid) seen++;
    end
    check({tag, "_no_stale"}, 32'(seen), 32'd0);
  endtask

  initial begin
    int   lat;
    int   ready_seen;
    exp_t mul_exp;
    int   mul_lat;

    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRL, OP_SRA, OP_SLL, OP_MUL};

    // flags field order: zero negative carry overflow invalid
    tbl[0]  = mkv(OP_ADD,    8'h7F, 8'h01, 8'h80, 5'b01010);
    tbl[1]  = mkv(OP_SUB,    8'h05, 8'h05, 8'h00, 5'b10100);
    tbl[2]  = mkv(OP_SUB,    8'h00, 8'h01, 8'hFF, 5'b01000);
    tbl[3]  = mkv(OP_SRA,    8'h80, 8'h03, 8'hF0, 5'b01000);
    tbl[4]  = mkv(OP_SRL,    8'h80, 8'h03, 8'h10, 5'b00000);
    tbl[5]  = mkv(OP_SLL,    8'h01, 8'h09, 8'h00, 5'b10000);
    tbl[6]  = mkv(6'b111111, 8'h00, 8'h00, 8'h00, 5'b00001);
    tbl[7]  = mkv(OP_ADD,    8'hFF, 8'h01, 8'h00, 5'b10100);
    tbl[8]  = mkv(OP_AND,    8'hF0, 8'h3C, 8'h30, 5'b00000);
    tbl[9]  = mkv(OP_OR,     8'hF0, 8'h0C, 8'hFC, 5'b01000);
    tbl[10] = mkv(OP_XOR,    8'hFF, 8'h0F, 8'hF0, 5'b01000);
    tbl[11] = mkv(OP_NOR,    8'h00, 8'h00, 8'hFF, 5'b01000);
    tbl[12] = mkv(OP_SRA,    8'h80, 8'h08, 8'hFF, 5'b01000);
    tbl[13] = mkv(OP_SRL,    8'hFF, 8'h08, 8'h00, 5'b10000);
    tbl[14] = mkv(OP_SUB,    8'h80, 8'h01, 8'h7F, 5'b00110);
    tbl[15] = mkv(OP_SLL,    8'h03, 8'h07, 8'h80, 5'b01000);

    // Reset state
    repeat (2) @(posedge i_clock);
    #1;
    check("reset_valid", 32'(o_valid), 32'd0);
    check("reset_out", 32'(dut_out()), 32'd0);
    @(negedge i_clock);
    i_reset = 1'b0;
    @(posedge i_clock); #1;
    check("reset_ready_after", 32'(o_ready), 32'd1);

    // Vector table: one op each, result visible one cycle after accept
    i_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge i_clock); #1;
      i_valid  = 1'b1;
      i_alu_Op = tbl[i].op;
      i_alu_A  = tbl[i].a;
      i_alu_B  = tbl[i].b;
      @(posedge i_clock); #1;
      i_valid = 1'b0;
      @(negedge i_clock);
      check($sformatf("vec%0d_valid", i), 32'(o_valid), 32'd1);
      check($sformatf("vec%0d_out", i), 32'(dut_out()), 32'(tbl[i].e));
    end

    // Back-pressure: second ADD waits while the first result is held
    go_idle();
    i_valid  = 1'b1;
    i_alu_Op = OP_ADD;
    i_alu_A  = 8'h10;
    i_alu_B  = 8'h20;
    @(posedge i_clock); #1;
    i_alu_A = 8'h01;
    i_alu_B = 8'h02;
    i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clock);
      check($sformatf("bp_hold%0d_valid", k), 32'(o_valid), 32'd1);
      check($sformatf("bp_hold%0d_out", k), 32'(dut_out()), 32'({8'h30, 5'b00000}));
      check($sformatf("bp_hold%0d_ready", k), 32'(o_ready), 32'd0);
      if (k < 2) @(posedge i_clock);
    end
    i_ready = 1'b1;
    #1;
    check("bp_ready_return", 32'(o_ready), 32'd1);
    @(posedge i_clock); #1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    @(negedge i_clock);
    check("bp_second_valid", 32'(o_valid), 32'd1);
    check("bp_second_out", 32'(dut_out()), 32'({8'h03, 5'b00000}));
    i_ready = 1'b1;
    @(posedge i_clock); #1;
    @(negedge i_clock);
    check("bp_no_dup", 32'(o_valid), 32'd0);

    // Multiply latency and busy back-pressure
`ifdef ALU_MUL_EN
    mul_exp = {8'h00, 5'b10010};
    mul_lat = 9;
`else
    mul_exp = {8'h00, 5'b00001};
    mul_lat = 1;
`endif
    go_idle();
    i_valid  = 1'b1;
    i_alu_Op = OP_MUL;
    i_alu_A  = 8'h10;
    i_alu_B  = 8'h10;
    @(posedge i_clock); #1;
    i_valid    = 1'b0;
    lat        = 0;
    ready_seen = 0;
    while (lat < 20) begin
      @(negedge i_clock);
      lat++;
      if (o_valid) break;
      if (o_ready) ready_seen++;
    end
    check("mul_latency", 32'(lat), 32'(mul_lat));
    check("mul_busy_ready", 32'(ready_seen), 32'd0);
    check("mul_out", 32'(dut_out()), 32'(mul_exp));

    // Asynchronous reset with an operation in flight
    rst_midflight("rst_mul", OP_MUL);
    rst_midflight("rst_done", OP_ADD);

    // Randomized traffic against the reference model, then drain
    go_idle();
    for (int c = 0; c < 800; c++) begin
      rnd_cycle(1'b1);
    end
    for (int c = 0; c < 40; c++) begin
      rnd_cycle(1'b0);
    end
    check("rnd_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
